inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Port clk  input  1  rising-edge clock; all state updates on this edge.
REQ-002 Port rst  input  1  reset: asynchronous, active-high (`RstEnable).
REQ-003 Port stall  input  6  pipeline stall vector; stall[1]==`Stop holds the decode stage.
REQ-004 Port branch_flag_i  input  1  branch/jump taken, redirect fetch.
REQ-005 Port branch_target_address_i  input  `InstAddrBus  redirect target.
REQ-006 Port flush  input  1  exception flush, highest priority.
REQ-007 Port new_pc  input  `InstAddrBus  exception handler address.
REQ-008 Port rom_ce  output  1  instruction ROM chip enable.
REQ-009 Port rom_addr  output  `InstAddrBus  ROM byte address; the ROM returns the word combinationally in the same cycle.
REQ-010 Port rom_inst  input  `InstBus  ROM read data.
REQ-011 Port if_valid  output  1  head of fetch buffer valid.
REQ-012 Port if_pc  output  `InstAddrBus  address of the head instruction.
REQ-013 Port if_inst  output  `InstBus  head instruction word.
REQ-014 Parameter FETCH_DEPTH, default 2, fetch buffer entries (power of two, >=2).

Function
REQ-015 pc register SHALL reset to 32'h00000000; rom_addr SHALL equal pc at all times.
REQ-016 ce register SHALL reset to `ChipDisable and become `ChipEnable on the first clk edge with rst deasserted; rom_ce SHALL equal ce.
REQ-017 deq SHALL be if_valid && stall[1]==`NoStop; it retires the buffer head.
REQ-018 enq SHALL be ce && !flush && !branch_flag_i && (count<FETCH_DEPTH || deq); on enq the buffer stores {pc, rom_inst} and pc <= pc+4.
REQ-019 Buffer full with deq in the same cycle SHALL enqueue and dequeue together; count unchanged.
REQ-020 Buffer full without deq SHALL hold pc and contents; no fetch is lost or duplicated.
REQ-021 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-022 flush SHALL empty the buffer and load pc <= {new_pc[31:2],2'b00} in the same cycle, regardless of stall.
REQ-023 branch_flag_i without flush SHALL empty the buffer and load pc <= {branch_target_address_i[31:2],2'b00}, regardless of stall.
REQ-024 Priority SHALL be rst > flush > branch_flag_i > enq/deq.
REQ-025 if_valid SHALL be count!=0; when empty, if_pc and if_inst SHALL read `ZeroWord.
REQ-026 Outputs if_* SHALL come from registered buffer state; fetch-to-if_valid latency is 1 cycle.
REQ-027 Buffer order SHALL be FIFO; read/write pointers wrap modulo FETCH_DEPTH.

Reset
REQ-028 rst SHALL clear pc, ce, count and pointers asynchronously, with no clock required; if_valid=0, if_pc=if_inst=`ZeroWord, rom_ce=`ChipDisable.
REQ-029 rst asserted mid-fetch or mid-redirect SHALL discard all buffered entries; the first fetch after release is address 0.

Structure
REQ-030 `InstAddrBus, `InstBus, `ZeroWord, `RstEnable, `ChipEnable/`ChipDisable, `Stop/`NoStop and a new `FetchBufDepth SHALL live in defines.v.
REQ-031 The buffer SHALL be one sub-module, inst_fifo (data, pointers, count, flush clear); the pc/redirect logic stays in inst_fetch.

Verification
REQ-032 Reset release, no stall, ROM word = address: the edge after release raises rom_ce; if_valid rises one cycle later with if_pc=0, if_inst=0; the sequence then proceeds 4, 8, ... every cycle.
REQ-033 stall[1]=`Stop held 5 cycles from pc=8: buffer fills to 2 entries (8, 0xC), pc holds at 0x10; on release, 8, 0xC, 0x10 emerge in order without loss.
REQ-034 branch_flag_i=1 with target 0x40 while buffer full: next cycle if_valid=0, rom_addr=0x40; then if_pc=0x40.
REQ-035 flush=1, new_pc=0x20, branch_flag_i=1 with target 0x80 in the same cycle: rom_addr becomes 0x20; target 0x83 is loaded as 0x80.
REQ-036 pc=0xFFFFFFFC, no stall: if_pc 0xFFFFFFFC, then 0x00000000.
REQ-037 rst pulsed asynchronously between edges with 2 entries buffered: outputs clear immediately; the first if_pc after release is 0.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package inst_fetch_pkg;

    localparam int unsigned InstAddrWidth = 32;
    localparam int unsigned InstWidth     = 32;
    localparam int unsigned FetchBufDepth = 2;

    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic [31:0] ResetPc     = 32'h0000_0000;
    localparam logic        RstEnable   = 1'b1;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        ChipDisable = 1'b0;
    localparam logic        Stop        = 1'b1;
    localparam logic        NoStop      = 1'b0;

    // One buffered fetch: the address it came from and the word the ROM returned.
    typedef struct packed {
        logic [InstAddrWidth-1:0] pc;
        logic [InstWidth-1:0]     inst;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [InstAddrWidth-1:0] word_align(input logic [InstAddrWidth-1:0] addr);
        return {addr[InstAddrWidth-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Fetch buffer: small FIFO of {pc, inst} pairs with a synchronous clear for redirects.
module inst_fifo
    import inst_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FetchBufDepth
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_inst,
    input  logic        pop,
    output logic        full,
    output logic        valid,
    output logic [31:0] head_pc,
    output logic [31:0] head_inst
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign valid   = (count_q != '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign do_pop  = pop && valid && !clear;
    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    assign do_push = push && !clear && (!full || do_pop);

    // Next pointers and occupancy; DEPTH is a power of two so pointers wrap on overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/count state, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset because the outputs are gated by valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= '{pc: push_pc, inst: push_inst};
    end

    // Head of the buffer reads as zero while empty.
    always_comb begin
        head_pc   = ZeroWord;
        head_inst = ZeroWord;
        if (valid) begin
            head_pc   = mem_q[rd_ptr_q].pc;
            head_inst = mem_q[rd_ptr_q].inst;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: pc sequencing, redirect on flush/branch, buffered output.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned FETCH_DEPTH = FetchBufDepth
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    input  logic        flush,
    input  logic [31:0] new_pc,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    logic [31:0] pc_q, pc_d;
    logic        ce_q;
    logic        deq, enq, redirect, buf_full;
    logic        unused_stall;

    // Only the decode-stage stall bit matters here.
    assign unused_stall = ^{stall[5:2], stall[0]};

    assign rom_ce   = ce_q;
    assign rom_addr = pc_q;

    assign redirect = flush || branch_flag_i;
    assign deq      = if_valid && (stall[1] == NoStop);
    assign enq      = (ce_q == ChipEnable) && !redirect && (!buf_full || deq);

    // Next pc: flush beats branch beats sequential fetch; a blocked fetch holds pc.
    always_comb begin
        pc_d = pc_q;
        if (flush) begin
            pc_d = word_align(new_pc);
        end else if (branch_flag_i) begin
            pc_d = word_align(branch_target_address_i);
        end else if (enq) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // pc and chip-enable state; ce comes up on the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= ResetPc;
            ce_q <= ChipDisable;
        end else begin
            pc_q <= pc_d;
            ce_q <= ChipEnable;
        end
    end

    inst_fifo #(
        .DEPTH (FETCH_DEPTH)
    ) u_inst_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (enq),
        .push_pc   (pc_q),
        .push_inst (rom_inst),
        .pop       (deq),
        .full      (buf_full),
        .valid     (if_valid),
        .head_pc   (if_pc),
        .head_inst (if_inst)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed table, hand sequences, randomized model run.
module tb_inst_fetch;

    localparam int Depth = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        flush;
    logic [31:0] new_pc;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    logic [31:0] rom_key = 32'h0;
    int          vectors = 0;
    int          miscompares = 0;

    // Reference model state: queue of buffered fetches, pc and chip enable.
    logic [31:0] mq_pc[$];
    logic [31:0] mq_inst[$];
    logic [31:0] m_pc;
    logic        m_ce;

    always #5 clk = ~clk;

    assign rom_inst = rom_addr ^ rom_key;

    inst_fetch #(
        .FETCH_DEPTH (Depth)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .rom_ce                  (rom_ce),
        .rom_addr                (rom_addr),
        .rom_inst                (rom_inst),
        .if_valid                (if_valid),
        .if_pc                   (if_pc),
        .if_inst                 (if_inst)
    );

    typedef struct {
        logic        stall1;
        logic        branch;
        logic [31:0] tgt;
        logic        flsh;
        logic [31:0] npc;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ rom_key;
    endfunction

    task automatic model_reset();
        mq_pc.delete();
        mq_inst.delete();
        m_pc = 32'h0;
        m_ce = 1'b0;
    endtask

    task automatic check_model();
        logic        ev;
        logic [31:0] ep, ei;
        ev = (mq_pc.size() != 0);
        ep = ev ? mq_pc[0] : 32'h0;
        ei = ev ? mq_inst[0] : 32'h0;
        check("if_valid", {31'b0, if_valid}, {31'b0, ev});
        check("if_pc", if_pc, ep);
        check("if_inst", if_inst, ei);
        check("rom_addr", rom_addr, m_pc);
        check("rom_ce", {31'b0, rom_ce}, {31'b0, m_ce});
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUT and compare.
    task automatic step();
        bit was_full, deq;
        was_full = (mq_pc.size() >= Depth);
        deq      = (mq_pc.size() != 0) && !stall[1];
        if (flush) begin
            mq_pc.delete();
            mq_inst.delete();
            m_pc = new_pc & 32'hFFFF_FFFC;
        end else if (branch_flag_i) begin
            mq_pc.delete();
            mq_inst.delete();
            m_pc = branch_target_address_i & 32'hFFFF_FFFC;
        end else begin
            if (deq) begin
                void'(mq_pc.pop_front());
                void'(mq_inst.pop_front());
            end
            if (m_ce && (!was_full || deq)) begin
                mq_pc.push_back(m_pc);
                mq_inst.push_back(rom_word(m_pc));
                m_pc = m_pc + 32'd4;
            end
        end
        m_ce = 1'b1;
        @(posedge clk);
        #1;
        check_model();
    endtask

    // Pulse reset between edges and confirm the outputs clear without a clock.
    task automatic async_reset_pulse();
        #2 rst = 1'b1;
        #1;
        check("rst_if_valid", {31'b0, if_valid}, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_inst", if_inst, 32'h0);
        check("rst_rom_ce", {31'b0, rom_ce}, 32'h0);
        check("rst_rom_addr", rom_addr, 32'h0);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic idle_inputs();
        stall                   = 6'b0;
        branch_flag_i           = 1'b0;
        branch_target_address_i = 32'h0;
        flush                   = 1'b0;
        new_pc                  = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();

        // Reset state before any clock edge.
        #2;
        check("reset_if_valid", {31'b0, if_valid}, 32'h0);
        check("reset_if_pc", if_pc, 32'h0);
        check("reset_if_inst", if_inst, 32'h0);
        check("reset_rom_ce", {31'b0, rom_ce}, 32'h0);
        check("reset_rom_addr", rom_addr, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // stall1 branch tgt flush npc | valid if_pc rom_addr (after the edge)
        tbl[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,  32'h0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h0,  32'h4};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h4,  32'h8};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h8,  32'hC};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h8,  32'h10};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h8,  32'h10};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h8,  32'h10};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h8,  32'h10};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h8,  32'h10};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'hC,  32'h14};
        tbl[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h10, 32'h18};
        tbl[11] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h10, 32'h18};
        tbl[12] = '{1'b0, 1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 32'h0,  32'h40};
        tbl[13] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h40, 32'h44};
        tbl[14] = '{1'b0, 1'b1, 32'h83, 1'b1, 32'h20, 1'b0, 32'h0,  32'h20};
        tbl[15] = '{1'b0, 1'b1, 32'h83, 1'b0, 32'h0,  1'b0, 32'h0,  32'h80};
        tbl[16] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h80, 32'h84};
        tbl[17] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFC};
        tbl[18] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'hFFFF_FFFC, 32'h0};
        tbl[19] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h0,  32'h4};

        for (int i = 0; i < 20; i++) begin
            stall                   = {4'b0, tbl[i].stall1, 1'b0};
            branch_flag_i           = tbl[i].branch;
            branch_target_address_i = tbl[i].tgt;
            flush                   = tbl[i].flsh;
            new_pc                  = tbl[i].npc;
            step();
            check($sformatf("tbl%0d_valid", i), {31'b0, if_valid}, {31'b0, tbl[i].exp_valid});
            check($sformatf("tbl%0d_pc", i), if_pc, tbl[i].exp_pc);
            check($sformatf("tbl%0d_inst", i), if_inst, tbl[i].exp_valid ? tbl[i].exp_pc : 32'h0);
            check($sformatf("tbl%0d_addr", i), rom_addr, tbl[i].exp_addr);
            check($sformatf("tbl%0d_ce", i), {31'b0, rom_ce}, 32'h1);
        end
        idle_inputs();

        // Fill the buffer to two entries, then reset between edges.
        stall = 6'b000010;
        step();
        check("fill_head", if_pc, 32'h0);
        check("fill_addr", rom_addr, 32'h8);
        async_reset_pulse();
        idle_inputs();
        step();
        check("post_rst_ce", {31'b0, rom_ce}, 32'h1);
        check("post_rst_valid", {31'b0, if_valid}, 32'h0);
        step();
        check("post_rst_first_pc", if_pc, 32'h0);
        check("post_rst_first_valid", {31'b0, if_valid}, 32'h1);

        // Randomized traffic against the queue model.
        rom_key = $urandom;
        for (int i = 0; i < 600; i++) begin
            stall = 6'($urandom);
            if ($urandom_range(0, 9) < 5) stall[1] = 1'b0;
            branch_flag_i           = ($urandom_range(0, 15) == 0);
            branch_target_address_i = $urandom;
            if ($urandom_range(0, 3) == 0) branch_target_address_i[31:4] = 28'hFFFF_FFF;
            flush  = ($urandom_range(0, 31) == 0);
            new_pc = $urandom;
            if ($urandom_range(0, 99) == 0) async_reset_pulse();
            step();
        end

        idle_inputs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
